// File: rtl/vending_pkg.sv
// Shared types, price table and coin constants for the vending machine.
// COIN_CHECK_EN selects which coin values an insertion accepts.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ESCOLHIDO = 2'd1,
    CREDITO   = 2'd2,
    ENTREGA   = 2'd3
  } state_t;

  localparam logic [7:0]  PRECO_P1     = 8'd50;
  localparam logic [7:0]  PRECO_P2     = 8'd75;
  localparam logic [7:0]  PRECO_P3     = 8'd100;
  localparam logic [7:0]  PRECO_P4     = 8'd125;
  localparam logic [7:0]  MAX_CREDIT   = 8'd255;
  localparam logic [15:0] CARTEIRA_MAX = 16'd65535;

  localparam logic [7:0]  MOEDA_25     = 8'd25;
  localparam logic [7:0]  MOEDA_50     = 8'd50;
  localparam logic [7:0]  MOEDA_100    = 8'd100;

  // A price of 0 marks an invalid product code.
  function automatic logic [7:0] preco_de(input logic [7:0] codigo);
    case (codigo)
      8'd1:    preco_de = PRECO_P1;
      8'd2:    preco_de = PRECO_P2;
      8'd3:    preco_de = PRECO_P3;
      8'd4:    preco_de = PRECO_P4;
      default: preco_de = 8'd0;
    endcase
  endfunction

  function automatic logic moeda_aceita(input logic [7:0] valor);
    moeda_aceita = (valor == MOEDA_25) || (valor == MOEDA_50) || (valor == MOEDA_100);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// One-bit rising-edge detector with synchronous active-high reset.
module detector_borda (
  input  logic clock,
  input  logic reset_n,
  input  logic i_sinal,
  output logic o_borda
);

  logic r_anterior;

  always_ff @(posedge clock) begin
    if (reset_n) r_anterior <= 1'b0;
    else         r_anterior <= i_sinal;
  end

  assign o_borda = i_sinal & ~r_anterior;

endmodule

// File: rtl/vending_machine.sv
// Vending machine controller: product select, credit, change and revenue.
// Define COIN_CHECK_EN to restrict insertions to 25/50/100 cent coins.
//   state     | meaning
//   IDLE      | no product chosen, no credit
//   ESCOLHIDO | product latched, no credit yet
//   CREDITO   | credit accumulating for the latched product
//   ENTREGA   | one-cycle dispense, strobes ignored
module vending_machine
  import vending_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        escolher,
  input  logic        inserir_dinheiro,
  input  logic        dar_troco,
  input  logic [7:0]  produto_escolhido,
  input  logic [7:0]  dinheiro_inserido,
  output logic        liberar,
  output logic [7:0]  produto_entregue,
  output logic [7:0]  troco,
  output logic        troco_valido,
  output logic [7:0]  credito,
  output logic [15:0] carteira,
  output logic        erro
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_produto, w_produto_nxt;
  logic [7:0]  r_credito, w_credito_nxt;
  logic [15:0] r_carteira, w_carteira_nxt;
  logic [7:0]  r_troco, w_troco_nxt;
  logic [7:0]  r_entregue, w_entregue_nxt;
  logic        r_troco_valido, w_troco_valido_nxt;
  logic        r_liberar, w_liberar_nxt;
  logic        r_erro, w_erro_nxt;

  logic        w_esc, w_ins, w_dt, w_multi, w_moeda_ok;
  logic [7:0]  w_preco;
  logic [8:0]  w_soma;
  logic [16:0] w_cart_soma;

  detector_borda u_borda_esc (.clock(clock), .reset_n(reset_n), .i_sinal(escolher),         .o_borda(w_esc));
  detector_borda u_borda_ins (.clock(clock), .reset_n(reset_n), .i_sinal(inserir_dinheiro), .o_borda(w_ins));
  detector_borda u_borda_dt  (.clock(clock), .reset_n(reset_n), .i_sinal(dar_troco),        .o_borda(w_dt));

  assign w_multi     = (w_esc & w_ins) | (w_esc & w_dt) | (w_ins & w_dt);
  assign w_preco     = preco_de(r_produto);
  assign w_soma      = {1'b0, r_credito} + {1'b0, dinheiro_inserido};
  assign w_cart_soma = {1'b0, r_carteira} + {9'd0, w_preco};

`ifdef COIN_CHECK_EN
  assign w_moeda_ok = moeda_aceita(dinheiro_inserido);
`else
  assign w_moeda_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset_n) begin
      r_state        <= IDLE;
      r_produto      <= 8'd0;
      r_credito      <= 8'd0;
      r_carteira     <= 16'd0;
      r_troco        <= 8'd0;
      r_entregue     <= 8'd0;
      r_troco_valido <= 1'b0;
      r_liberar      <= 1'b0;
      r_erro         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_produto      <= w_produto_nxt;
      r_credito      <= w_credito_nxt;
      r_carteira     <= w_carteira_nxt;
      r_troco        <= w_troco_nxt;
      r_entregue     <= w_entregue_nxt;
      r_troco_valido <= w_troco_valido_nxt;
      r_liberar      <= w_liberar_nxt;
      r_erro         <= w_erro_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_produto_nxt      = r_produto;
    w_credito_nxt      = r_credito;
    w_carteira_nxt     = r_carteira;
    w_troco_nxt        = r_troco;
    w_entregue_nxt     = r_entregue;
    w_troco_valido_nxt = 1'b0;
    w_liberar_nxt      = 1'b0;
    w_erro_nxt         = 1'b0;

    if (r_state == ENTREGA) begin
      w_state_nxt = IDLE;
    end else if (w_multi) begin
      w_erro_nxt = 1'b1;
    end else if (w_esc) begin
      if (r_state == CREDITO || preco_de(produto_escolhido) == 8'd0) begin
        w_erro_nxt = 1'b1;
      end else begin
        w_produto_nxt = produto_escolhido;
        w_state_nxt   = ESCOLHIDO;
      end
    end else if (w_ins) begin
      if (r_state == IDLE || !w_moeda_ok) begin
        w_erro_nxt = 1'b1;
      end else if (dinheiro_inserido == 8'd0) begin
        w_state_nxt = r_state;
      end else if (w_soma > {1'b0, MAX_CREDIT}) begin
        w_erro_nxt = 1'b1;
      end else begin
        w_credito_nxt = w_soma[7:0];
        w_state_nxt   = CREDITO;
      end
    end else if (w_dt) begin
      w_troco_valido_nxt = 1'b1;
      w_credito_nxt      = 8'd0;
      if (r_state != CREDITO) begin
        w_troco_nxt = 8'd0;
        w_state_nxt = IDLE;
      end else if (r_credito >= w_preco) begin
        w_troco_nxt    = r_credito - w_preco;
        w_carteira_nxt = (w_cart_soma > {1'b0, CARTEIRA_MAX}) ? CARTEIRA_MAX : w_cart_soma[15:0];
        w_liberar_nxt  = 1'b1;
        w_entregue_nxt = r_produto;
        w_state_nxt    = ENTREGA;
      end else begin
        w_troco_nxt = r_credito;
        w_erro_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
    end
  end

  assign liberar          = r_liberar;
  assign produto_entregue = r_entregue;
  assign troco            = r_troco;
  assign troco_valido     = r_troco_valido;
  assign credito          = r_credito;
  assign carteira         = r_carteira;
  assign erro             = r_erro;

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-high reset; the name is kept as the codebase name.
REQ-003 SHALL have port escolher, input, 1 bit: product-select strobe, a level held one or more cycles.
REQ-004 SHALL have port inserir_dinheiro, input, 1 bit: money-insert strobe, a level held one or more cycles.
REQ-005 SHALL have port dar_troco, input, 1 bit: finish and return change, a level held one or more cycles.
REQ-006 SHALL have port produto_escolhido, input, 8 bits: product code, sampled on the escolher edge.
REQ-007 SHALL have port dinheiro_inserido, input, 8 bits: amount in cents, sampled on the inserir_dinheiro edge.
REQ-008 SHALL have port liberar, output, 1 bit: one-cycle dispense pulse.
REQ-009 SHALL have port produto_entregue, output, 8 bits: code of the dispensed product, held until the next dispense.
REQ-010 SHALL have port troco, output, 8 bits: change in cents, valid while troco_valido is high, otherwise held.
REQ-011 SHALL have port troco_valido, output, 1 bit: one-cycle change-valid pulse.
REQ-012 SHALL have port credito, output, 8 bits: credit in cents for the current transaction.
REQ-013 SHALL have port carteira, output, 16 bits: cumulative revenue in cents.
REQ-014 SHALL have port erro, output, 1 bit: one-cycle error pulse.

Function
REQ-015 Each strobe SHALL act only on its rising edge: sampled high now, low on the previous cycle.
- Outputs update at that same clock edge.
- Latency: 1 cycle from the strobe transition.
REQ-016 The FSM SHALL use states IDLE, ESCOLHIDO, CREDITO, ENTREGA.
REQ-017 Price table SHALL be: code 1 = 50, 2 = 75, 3 = 100, 4 = 125; any other code is invalid.
REQ-018 escolher edge in IDLE:
- Valid code -> latch product, go to ESCOLHIDO.
- Invalid code -> erro pulse, stay in IDLE.
REQ-019 escolher edge in ESCOLHIDO SHALL replace the latched product if the code is valid; otherwise erro pulse and the product is kept.
REQ-020 escolher edge in CREDITO SHALL cause an erro pulse with no state change.
REQ-021 inserir_dinheiro edge in ESCOLHIDO or CREDITO:
- credito += dinheiro_inserido, state goes to CREDITO.
- If the sum would exceed 255 -> amount is refused, erro pulse, credito unchanged.
REQ-022 inserir_dinheiro edge in IDLE SHALL cause an erro pulse and no credit.
REQ-023 dar_troco edge in CREDITO with credito >= price:
- Go to ENTREGA.
- troco = credito - price, troco_valido pulse.
- carteira += price, saturating at 65535.
- credito cleared.
REQ-024 dar_troco edge in CREDITO with credito < price:
- troco = credito, troco_valido pulse, erro pulse.
- credito cleared, carteira unchanged, go to IDLE.
REQ-025 dar_troco edge in IDLE or ESCOLHIDO:
- troco = 0, troco_valido pulse, go to IDLE.
- No erro.
REQ-026 ENTREGA SHALL last exactly 1 cycle: liberar high, produto_entregue = latched code, then IDLE; strobe edges arriving in ENTREGA are ignored.
REQ-027 More than one strobe edge in the same cycle SHALL produce an erro pulse; none of the actions is executed and the state is unchanged.
REQ-028 All arithmetic SHALL be unsigned; credito and troco never go negative and never wrap.

Reset
REQ-029 reset_n high at a clock edge SHALL give: state IDLE; all outputs 0; edge-detect history 0; latched product 0.
REQ-030 Reset mid-transaction SHALL discard the credit with no change output; reset takes priority over all strobes.

Configuration
REQ-031 With COIN_CHECK_EN defined:
- An insertion SHALL be accepted only if dinheiro_inserido is 25, 50 or 100.
- Any other value -> erro pulse, no credit, state unchanged.
REQ-032 Without COIN_CHECK_EN, any value 1..255 SHALL be accepted (subject to REQ-021); a value of 0 is a no-op with no erro.

Structure
REQ-033 Package vending_pkg SHALL hold:
- FSM state enum.
- Product price constants and the price lookup function.
- MAX_CREDIT = 255 and CARTEIRA_MAX = 65535.
- Accepted coin constants.
REQ-034 Sub-module detector_borda (1-bit rising-edge detector, synchronous reset) SHALL be instantiated once per strobe.

Verification
REQ-035 Product 1 select, insert 150, dar_troco -> troco=100, liberar pulse, produto_entregue=1, carteira=50.
REQ-036 Then product 2 select, insert 100, dar_troco -> troco=25, carteira=125.
REQ-037 Product 4 select, insert 100, dar_troco -> troco=100, erro pulse, no liberar, carteira unchanged.
REQ-038 Select product 3, insert 200, then insert 100 -> second insertion refused (erro), credito=200; dar_troco -> troco=100.
REQ-039 escolher and inserir_dinheiro rising in the same cycle -> erro, state unchanged; reset asserted in CREDITO -> all outputs 0, state IDLE.
REQ-040 With COIN_CHECK_EN: insert 30 -> erro, credito 0; insert 25 -> credito=25; the same insertion level held 5 cycles credits only once.
